// File: rtl/uart_pkg.sv
// Shared UART-16550 definitions: TX FIFO sequencer states, default FIFO depth
// and FCR bit positions.
package uart_pkg;

    localparam int UART_FIFO_DEPTH = 16;

    localparam int FCR_FIFO_EN = 0;
    localparam int FCR_TX_CLR  = 2;

    typedef enum logic [1:0] {
        TXF_IDLE   = 2'd0,
        TXF_LAUNCH = 2'd1,
        TXF_ARM    = 2'd2,
        TXF_BUSY   = 2'd3
    } txf_state_e;

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x WIDTH register array: synchronous write, asynchronous read.
// Shared by the UART TX and RX FIFOs.
module uart_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmit holding FIFO: buffers host THR writes and launches them into the
// serializer one at a time. Optional sticky overrun flag under TXF_OVERRUN_EN.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = UART_FIFO_DEPTH,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   fifo_en,
    input  logic                   fifo_clr,
    input  logic                   tx_thr_empty,
    output logic                   write_thr,
    output logic [WIDTH-1:0]       thr_data,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty,
    output logic                   thre,
    output logic                   temt
`ifdef TXF_OVERRUN_EN
    ,
    output logic                   overrun
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] CAP_FIFO = CW'(DEPTH);
    localparam logic [CW-1:0] CAP_ONE  = CW'(1);

    txf_state_e    state_q, state_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] cap;
    logic          fifo_en_q;
    logic          clr, pop, push;

    // A mode switch empties the buffer exactly like an FCR clear.
    assign cap   = fifo_en ? CAP_FIFO : CAP_ONE;
    assign clr   = fifo_clr | (fifo_en != fifo_en_q);
    assign empty = (count_q == '0);
    assign full  = (count_q == cap);
    assign pop   = (state_q == TXF_LAUNCH);
    assign push  = wr_en & (~full | pop) & ~clr;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clr) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Clears never touch the sequencer, so a launched character still finishes.
    always_comb begin
        state_d = state_q;
        case (state_q)
            TXF_IDLE:   if (!empty && tx_thr_empty && !clr) state_d = TXF_LAUNCH;
            TXF_LAUNCH: state_d = TXF_ARM;
            TXF_ARM:    state_d = TXF_BUSY;
            TXF_BUSY:   if (tx_thr_empty) state_d = TXF_IDLE;
            default:    state_d = TXF_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        fifo_en_q <= fifo_en;
        if (rst) begin
            state_q  <= TXF_IDLE;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    uart_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_mem (
        .clk     (clk),
        .we_i    (push & ~rst),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_data),
        .raddr_i (rd_ptr_q),
        .rdata_o (thr_data)
    );

    assign write_thr = pop;
    assign level     = count_q;
    assign thre      = empty;
    assign temt      = empty & tx_thr_empty & (state_q == TXF_IDLE);

`ifdef TXF_OVERRUN_EN
    logic overrun_q;

    always_ff @(posedge clk) begin
        if (rst || fifo_clr) begin
            overrun_q <= 1'b0;
        end else if (wr_en && full && !pop && !clr) begin
            overrun_q <= 1'b1;
        end
    end

    assign overrun = overrun_q;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized scoreboard bench for uart_tx_fifo against a queue-based reference model.
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;
    localparam int WIDTH = 8;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             wr_en = 1'b0;
    logic [WIDTH-1:0] wr_data = '0;
    logic             fifo_en = 1'b1;
    logic             fifo_clr = 1'b0;
    logic             tx_thr_empty = 1'b1;
    logic             write_thr;
    logic [WIDTH-1:0] thr_data;
    logic [LW-1:0]    level;
    logic             full, empty, thre, temt;
`ifdef TXF_OVERRUN_EN
    logic             overrun;
`endif

    always #5 clk = ~clk;

    uart_tx_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .fifo_en      (fifo_en),
        .fifo_clr     (fifo_clr),
        .tx_thr_empty (tx_thr_empty),
        .write_thr    (write_thr),
        .thr_data     (thr_data),
        .level        (level),
        .full         (full),
        .empty        (empty),
        .thre         (thre),
        .temt         (temt)
`ifdef TXF_OVERRUN_EN
        ,
        .overrun      (overrun)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: stored characters, launch sequence phase
    // (0 ready, 1 launching, 2 settling, 3 waiting for tx), sticky overrun.
    logic [7:0] mq[$];
    logic [7:0] exp_q[$];
    int         m_phase = 0;
    bit         m_ov = 1'b0;
    bit         m_fen_prev = 1'b1;
    bit         started = 1'b0;

    // Serializer emulation
    int tx_left  = 0;
    int busy_len = 3;
    bit hold_te  = 1'b0;
    bit fen_v    = 1'b1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        int cap;
        bit m_empty;
        cap     = fifo_en ? DEPTH : 1;
        m_empty = (mq.size() == 0);
        chk("level", int'(level), mq.size());
        chk("empty", int'(empty), int'(m_empty));
        chk("full", int'(full), int'(mq.size() == cap));
        chk("thre", int'(thre), int'(m_empty));
        chk("temt", int'(temt), int'(m_empty && tx_thr_empty && m_phase == 0));
        chk("write_thr", int'(write_thr), int'(m_phase == 1));
`ifdef TXF_OVERRUN_EN
        chk("overrun", int'(overrun), int'(m_ov));
`endif
    endtask

    task automatic model_step(input bit wr, input logic [7:0] d, input bit fen,
                              input bit clr, input bit te, input bit r);
        bit clear, pop, was_full, was_empty, acc;
        int cap, np;
        logic [7:0] tmp;
        if (r) begin
            mq.delete();
            m_phase = 0;
            m_ov    = 1'b0;
            started = 1'b1;
        end else begin
            clear     = clr || (fen != m_fen_prev);
            pop       = (m_phase == 1);
            cap       = fen ? DEPTH : 1;
            was_full  = (mq.size() == cap);
            was_empty = (mq.size() == 0);
            acc       = wr && (!was_full || pop) && !clear;
            if (clr) m_ov = 1'b0;
            else if (wr && was_full && !pop && !clear) m_ov = 1'b1;
            np = m_phase;
            case (m_phase)
                0: if (!was_empty && te && !clear) np = 1;
                1: np = 2;
                2: np = 3;
                default: np = te ? 0 : 3;
            endcase
            if (clear) begin
                mq.delete();
            end else begin
                if (pop && mq.size() > 0) tmp = mq.pop_front();
                if (acc) mq.push_back(d);
            end
            if (np == 1) exp_q.push_back(mq[0]);
            m_phase = np;
        end
        m_fen_prev = fen;
    endtask

    task automatic cycle(input bit wr, input logic [7:0] d, input bit clr, input bit r);
        bit te;
        @(negedge clk);
        if (started) check_outputs();
        if (m_phase == 1) tx_left = busy_len;
        te = !hold_te && (tx_left == 0);
        if (tx_left > 0) tx_left--;
        rst          = r;
        wr_en        = wr;
        wr_data      = d;
        fifo_clr     = clr;
        fifo_en      = fen_v;
        tx_thr_empty = te;
        model_step(wr, d, fen_v, clr, te, r);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic wait_phase(input int p, input int limit);
        int k;
        k = 0;
        while (m_phase != p && k < limit) begin
            cycle(1'b0, 8'h00, 1'b0, 1'b0);
            k++;
        end
        n_checks++;
        if (m_phase != p) begin
            n_fail++;
            $display("FAIL wait_phase%0d: timed out after %0d cycles", p, limit);
        end
    endtask

    // Monitor: every launch must match the next expected character.
    always @(negedge clk) begin
        logic [7:0] e;
        if (started && write_thr === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_launch: thr_data %02h with nothing expected at %0t",
                         thr_data, $time);
            end else begin
                e = exp_q.pop_front();
                chk("thr_data", int'(thr_data), int'(e));
            end
        end
    end

    initial begin
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);

        // Single character into an idle transmitter
        cycle(1'b1, 8'h55, 1'b0, 1'b0);
        idle(12);

        // Fill to full while tx is busy, then overrun and write-during-pop
        hold_te = 1'b1;
        for (int i = 1; i <= 16; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
        idle(1);
        cycle(1'b1, 8'hAA, 1'b0, 1'b0);
        idle(1);
        hold_te = 1'b0;
        wait_phase(1, 10);
        cycle(1'b1, 8'hAB, 1'b0, 1'b0);
        idle(200);

        // Single-entry holding register mode
        fen_v = 1'b0;
        idle(2);
        hold_te = 1'b1;
        cycle(1'b1, 8'h11, 1'b0, 1'b0);
        cycle(1'b1, 8'h22, 1'b0, 1'b0);
        idle(2);
        hold_te = 1'b0;
        idle(20);

        // Clear with coincident write while BUSY with 5 entries
        fen_v = 1'b1;
        idle(2);
        busy_len = 40;
        for (int i = 0; i < 6; i++) cycle(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
        wait_phase(3, 10);
        cycle(1'b1, 8'hEE, 1'b1, 1'b0);
        idle(60);
        busy_len = 3;

        // Mode toggle with 3 entries
        hold_te = 1'b1;
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        fen_v = 1'b0;
        idle(1);
        fen_v = 1'b1;
        idle(1);
        hold_te = 1'b0;
        idle(5);

        // Reset during ARM
        cycle(1'b1, 8'h5A, 1'b0, 1'b0);
        wait_phase(2, 10);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        idle(10);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 79) == 0) fen_v = !fen_v;
            hold_te  = ($urandom_range(0, 7) == 0);
            busy_len = int'($urandom_range(1, 6));
            cycle(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                  ($urandom_range(0, 39) == 0), ($urandom_range(0, 299) == 0));
        end

        fen_v   = 1'b1;
        hold_te = 1'b0;
        idle(250);
        chk("exp_q_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
